// File: rtl/serial_sync_framer_pkg.sv
// Shared types and helpers for the 11101 sync-word serial framer.
package serial_sync_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PAR,
        GAP
    } state_e;

    localparam int unsigned     SYNC_LEN_DEFAULT  = 5;
    localparam logic [4:0]      SYNC_WORD_DEFAULT = 5'b11101;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/serial_sync_framer_if.sv
// Payload valid/ready handshake into the serial framer.
interface serial_sync_framer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/serial_sync_framer_piso_shifter.sv
// Parallel-in serial-out shifter: parallel load, shift left, MSB is the registered line bit.
module piso_shifter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    output logic         msb
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_val;
        end else if (shift) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[W-1];

endmodule

// File: rtl/serial_sync_framer.sv
// Serial framer: SYNC_WORD + payload (+ even parity when SERIAL_FRAMER_PARITY_EN) + zero gap, MSB first.
module serial_sync_framer
    import serial_sync_pkg::*;
#(
    parameter int unsigned         SYNC_LEN  = SYNC_LEN_DEFAULT,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(SYNC_WORD_DEFAULT),
    parameter int unsigned         DATA_W    = 8,
    parameter int unsigned         GAP_LEN   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_sync_framer_if.slave  bus,
    output logic                 dataout,
    output logic                 frame_active,
    output logic                 frame_done
);

    localparam int unsigned SH_W    = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int unsigned MAX_LEN = max3(SYNC_LEN, DATA_W, GAP_LEN);
    localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [SH_W-1:0] SYNC_ALIGNED = SH_W'(SYNC_WORD) << (SH_W - SYNC_LEN);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   payload_q, payload_d;
    logic                ready_q, ready_d;
    logic                active_q, active_d;
    logic                done_q, done_d;

    logic                sh_load;
    logic                sh_shift;
    logic [SH_W-1:0]     sh_val;

    // Next state; the down-counter is reloaded on every state entry and 0 is the terminal count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        payload_d = payload_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_val    = '0;

        case (state_q)
            IDLE: begin
                if (bus.data_valid) begin
                    state_d   = SYNC;
                    cnt_d     = CNT_W'(SYNC_LEN - 1);
                    payload_d = bus.data_in;
                    sh_load   = 1'b1;
                    sh_val    = SYNC_ALIGNED;
                end
            end
            SYNC: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    sh_load = 1'b1;
                    sh_val  = SH_W'(payload_q) << (SH_W - DATA_W);
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    sh_shift = 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
`ifdef SERIAL_FRAMER_PARITY_EN
                    state_d = PAR;
                    cnt_d   = '0;
                    sh_load = 1'b1;
                    sh_val  = SH_W'(even_parity(32'(payload_q))) << (SH_W - 1);
`else
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_LEN - 1);
                    sh_load = 1'b1;
                    sh_val  = '0;
`endif
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    sh_shift = 1'b1;
                end
            end
`ifdef SERIAL_FRAMER_PARITY_EN
            PAR: begin
                state_d = GAP;
                cnt_d   = CNT_W'(GAP_LEN - 1);
                sh_load = 1'b1;
                sh_val  = '0;
            end
`endif
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ready_d  = (state_d == IDLE);
        active_d = (state_d != IDLE);
        done_d   = (state_d == GAP) && (cnt_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            payload_q <= '0;
            ready_q   <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            payload_q <= payload_d;
            ready_q   <= ready_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // Line bit is the shifter's registered MSB; it holds zero outside SYNC/DATA/PAR.
    piso_shifter #(
        .W (SH_W)
    ) u_piso (
        .clock    (clock),
        .reset    (reset),
        .load     (sh_load),
        .shift    (sh_shift),
        .load_val (sh_val),
        .msb      (dataout)
    );

    assign bus.data_ready = ready_q;
    assign frame_active   = active_q;
    assign frame_done     = done_q;

endmodule

// File: tb/tb_serial_sync_framer.sv
// Self-checking bench for serial_sync_framer against a frame-level reference model.
module tb_serial_sync_framer;

    localparam int SYNC_LEN = 5;
    localparam int DATA_W   = 8;
    localparam int GAP_LEN  = 2;
`ifdef SERIAL_FRAMER_PARITY_EN
    localparam int PAR_LEN  = 1;
`else
    localparam int PAR_LEN  = 0;
`endif
    localparam int FLEN     = SYNC_LEN + DATA_W + PAR_LEN + GAP_LEN;
    localparam int NSTEP    = 3 * (FLEN + 1);

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dataout;
    logic frame_active;
    logic frame_done;

    serial_sync_framer_if #(.DATA_W(DATA_W)) bus ();

    serial_sync_framer #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (5'b11101),
        .DATA_W    (DATA_W),
        .GAP_LEN   (GAP_LEN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .dataout      (dataout),
        .frame_active (frame_active),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic exp_dout [0:FLEN];
    logic obs_dout [0:FLEN];
    logic obs_act  [0:FLEN];
    logic obs_done [0:FLEN];
    logic obs_rdy  [0:FLEN];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected line bits for one frame, index 0 = first cycle after the accept edge.
    task automatic build_expected(input logic [7:0] w);
        logic [4:0] sp;
        sp = 5'b11101;
        for (int i = 0; i <= FLEN; i++) exp_dout[i] = 1'b0;
        for (int i = 0; i < SYNC_LEN; i++) exp_dout[i] = sp[SYNC_LEN-1-i];
        for (int i = 0; i < DATA_W; i++) exp_dout[SYNC_LEN+i] = w[DATA_W-1-i];
`ifdef SERIAL_FRAMER_PARITY_EN
        exp_dout[SYNC_LEN+DATA_W] = ^w;
`endif
    endtask

    // Offer one word from idle and record FLEN+1 cycles of outputs.
    task automatic capture_frame(input logic [7:0] w);
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.data_in    = 8'($urandom);
        for (int i = 0; i <= FLEN; i++) begin
            obs_dout[i] = dataout;
            obs_act[i]  = frame_active;
            obs_done[i] = frame_done;
            obs_rdy[i]  = bus.data_ready;
            tick();
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hFF;
        repeat (3) tick();
        bus.data_valid = 1'b0;
        reset          = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (dataout !== 1'b0) begin
                n_fail++; $display("FAIL reset_dataout cycle %0d: got %b want 0", c, dataout);
            end
            n_checks++;
            if (bus.data_ready !== 1'b1) begin
                n_fail++; $display("FAIL reset_ready cycle %0d: got %b want 1", c, bus.data_ready);
            end
            n_checks++;
            if (frame_active !== 1'b0 || frame_done !== 1'b0) begin
                n_fail++; $display("FAIL reset_active_done cycle %0d: got %b/%b want 0/0", c, frame_active, frame_done);
            end
        end
    endtask

    task automatic test_frame_a5();
        logic [FLEN-1:0] a5_ref;
`ifdef SERIAL_FRAMER_PARITY_EN
        a5_ref = 16'b1110110100101000;
`else
        a5_ref = 15'b111011010010100;
`endif
        capture_frame(8'hA5);
        for (int i = 0; i <= FLEN; i++) begin
            n_checks++;
            if (obs_dout[i] !== ((i < FLEN) ? a5_ref[FLEN-1-i] : 1'b0)) begin
                n_fail++; $display("FAIL a5_dataout cycle %0d: got %b", i + 1, obs_dout[i]);
            end
            n_checks++;
            if (obs_act[i] !== (i < FLEN)) begin
                n_fail++; $display("FAIL a5_active cycle %0d: got %b want %b", i + 1, obs_act[i], i < FLEN);
            end
            n_checks++;
            if (obs_done[i] !== (i == FLEN - 1)) begin
                n_fail++; $display("FAIL a5_done cycle %0d: got %b want %b", i + 1, obs_done[i], i == FLEN - 1);
            end
            n_checks++;
            if (obs_rdy[i] !== (i == FLEN)) begin
                n_fail++; $display("FAIL a5_ready cycle %0d: got %b want %b", i + 1, obs_rdy[i], i == FLEN);
            end
        end
    endtask

`ifdef SERIAL_FRAMER_PARITY_EN
    task automatic test_parity();
        capture_frame(8'h07);
        n_checks++;
        if (obs_dout[SYNC_LEN+DATA_W] !== 1'b1) begin
            n_fail++; $display("FAIL parity_07: got %b want 1", obs_dout[SYNC_LEN+DATA_W]);
        end
        n_checks++;
        if (obs_done[15] !== 1'b1 || obs_rdy[16] !== 1'b1) begin
            n_fail++; $display("FAIL parity_len16: done@16=%b ready@17=%b want 1/1", obs_done[15], obs_rdy[16]);
        end
        capture_frame(8'h03);
        n_checks++;
        if (obs_dout[SYNC_LEN+DATA_W] !== 1'b0) begin
            n_fail++; $display("FAIL parity_03: got %b want 0", obs_dout[SYNC_LEN+DATA_W]);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] w_arr   [0:NSTEP-1];
        logic       rdy_arr [0:NSTEP-1];
        logic       dout_arr[0:NSTEP-1];
        logic       exp_rdy [0:NSTEP-1];
        logic       exp_line[0:NSTEP-1];
        int next_free;
        int accepts;

        bus.data_valid = 1'b1;
        for (int c = 0; c < NSTEP; c++) begin
            w_arr[c]    = 8'($urandom);
            bus.data_in = w_arr[c];
            rdy_arr[c]  = bus.data_ready;
            tick();
            dout_arr[c] = dataout;
        end
        bus.data_valid = 1'b0;

        for (int c = 0; c < NSTEP; c++) exp_line[c] = 1'b0;
        next_free = 0;
        for (int c = 0; c < NSTEP; c++) begin
            exp_rdy[c] = (c >= next_free);
            if (c >= next_free) begin
                build_expected(w_arr[c]);
                for (int k = 0; k < FLEN; k++) exp_line[c+k] = exp_dout[k];
                next_free = c + FLEN + 1;
            end
        end

        accepts = 0;
        for (int c = 0; c < NSTEP; c++) begin
            if (rdy_arr[c] === 1'b1) accepts++;
            n_checks++;
            if (rdy_arr[c] !== exp_rdy[c]) begin
                n_fail++; $display("FAIL b2b_ready step %0d: got %b want %b", c, rdy_arr[c], exp_rdy[c]);
            end
            n_checks++;
            if (dout_arr[c] !== exp_line[c]) begin
                n_fail++; $display("FAIL b2b_dataout step %0d: got %b want %b", c, dout_arr[c], exp_line[c]);
            end
        end
        n_checks++;
        if (accepts != 3) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d want 3", accepts);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        w = 8'($urandom);
        build_expected(w);
        bus.data_in    = w;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            n_checks++;
            if (dataout !== exp_dout[c-1]) begin
                n_fail++; $display("FAIL midrst_pre cycle %0d: got %b want %b", c, dataout, exp_dout[c-1]);
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (dataout !== 1'b0 || bus.data_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_after: dataout=%b ready=%b want 0/1", dataout, bus.data_ready);
        end
        for (int c = 0; c < 20; c++) begin
            n_checks++;
            if (frame_done !== 1'b0 || frame_active !== 1'b0) begin
                n_fail++; $display("FAIL midrst_quiet cycle %0d: done=%b active=%b want 0/0", c, frame_done, frame_active);
            end
            tick();
        end
        w = 8'($urandom);
        build_expected(w);
        capture_frame(w);
        for (int i = 0; i <= FLEN; i++) begin
            n_checks++;
            if (obs_dout[i] !== exp_dout[i] || obs_done[i] !== (i == FLEN - 1)) begin
                n_fail++; $display("FAIL midrst_next cycle %0d: dout=%b done=%b want %b/%b", i + 1, obs_dout[i], obs_done[i], exp_dout[i], i == FLEN - 1);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] w;
        for (int f = 0; f < 8; f++) begin
            case (f)
                0: w = 8'h00;
                1: w = 8'hFF;
                2: w = 8'h80;
                3: w = 8'h01;
                default: w = 8'($urandom);
            endcase
            build_expected(w);
            capture_frame(w);
            for (int i = 0; i <= FLEN; i++) begin
                n_checks++;
                if (obs_dout[i] !== exp_dout[i]) begin
                    n_fail++; $display("FAIL rand_dataout word %h cycle %0d: got %b want %b", w, i + 1, obs_dout[i], exp_dout[i]);
                end
                n_checks++;
                if (obs_done[i] !== (i == FLEN - 1) || obs_rdy[i] !== (i == FLEN)) begin
                    n_fail++; $display("FAIL rand_ctrl word %h cycle %0d: done=%b ready=%b", w, i + 1, obs_done[i], obs_rdy[i]);
                end
            end
        end
    endtask

    // Receiver-side view: count 11101 occurrences in the line stream, overlaps allowed.
    task automatic test_detector();
        logic [4:0] win;
        int hits;
        int total;
        win   = '0;
        total = 0;
        for (int f = 0; f < 3; f++) begin
            capture_frame(8'h00);
            hits = 0;
            for (int i = 0; i <= FLEN; i++) begin
                win = {win[3:0], obs_dout[i]};
                if (win == 5'b11101) hits++;
            end
            total += hits;
            n_checks++;
            if (hits != 1) begin
                n_fail++; $display("FAIL detector_frame %0d: got %0d hits want 1", f, hits);
            end
        end
        n_checks++;
        if (total != 3) begin
            n_fail++; $display("FAIL detector_total: got %0d want 3", total);
        end
    endtask

    initial begin
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        test_reset();
        test_frame_a5();
`ifdef SERIAL_FRAMER_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_detector();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
